alu_nibble_seq: RTL and testbench
=================================

ALU_NIBBLE_SEQ -- requirements
Module: alu_nibble_seq

Interface
REQ-001 SHALL have parameter: NIBBLES, default 4, number of 4-bit slices processed per operation (W = 4*NIBBLES).
REQ-002 SHALL have one clock and an asynchronous, active-high reset.
REQ-003 SHALL have ports:
- clk  in  1  clock.
- reset  in  1  asynchronous reset, active high.
- start  in  1  request a new operation.
- op_s  in  4  function select, passed to the 4-bit ALU slice s.
- op_m  in  1  mode bit (1 = logic, 0 = arithmetic).
- op_ci_n  in  1  active-low carry into nibble 0.
- a_in  in  W  operand A.
- b_in  in  W  operand B.
- busy  out  1  operation in progress.
- done  out  1  one-cycle result-valid strobe.
- result  out  W  assembled F output.
- co_n  out  1  active-low carry out of the top nibble.
- aeqb  out  1  AND of all nibble aeqb outputs.
- alu_a  out  4  current nibble of A to the slice.
- alu_b  out  4  current nibble of B to the slice.
- alu_s  out  4  select to the slice.
- alu_m  out  1  mode to the slice.
- alu_ci_n  out  1  carry to the slice.
- alu_f  in  4  slice F.
- alu_co_n  in  1  slice carry out.
- alu_aeqb  in  1  slice A=B.

Function
REQ-004 SHALL implement FSM states IDLE, RUN, DONE; reset state is IDLE.
REQ-005 IDLE: start=1 at a rising edge SHALL latch a_in, b_in, op_s, op_m, op_ci_n into internal registers, clear the nibble index to 0, clear result, preset the aeqb accumulator to 1, and move to RUN.
REQ-006 IDLE: start=0 SHALL hold all outputs unchanged, so result, co_n and aeqb keep the last values.
REQ-007 RUN: alu_a and alu_b SHALL be combinational selections of latched A/B bits [4*idx+3:4*idx].
REQ-008 RUN: alu_s and alu_m SHALL equal the latched op; alu_ci_n SHALL be the latched op_ci_n when idx=0, otherwise the carry register.
REQ-009 RUN: each rising edge SHALL write alu_f into result[4*idx+3:4*idx], load the carry register with alu_co_n, AND alu_aeqb into the accumulator, and increment idx.
REQ-010 RUN: the edge that captures idx=NIBBLES-1 SHALL also load co_n from alu_co_n, load aeqb from the final accumulator, and move to DONE.
REQ-011 DONE: done SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-012 busy SHALL be 1 in RUN and DONE and 0 in IDLE.
REQ-013 Latency: start sampled at edge k SHALL give done=1 in the cycle following edge k+NIBBLES (NIBBLES+1 cycles from start to done).
REQ-014 start while busy=1 SHALL be ignored, with no queuing; start asserted in the DONE cycle SHALL also be ignored.
REQ-015 Operand inputs changing during RUN SHALL NOT affect the operation in progress.
REQ-016 In IDLE and DONE, alu_* outputs SHALL present nibble 0 of the latched operands with the latched op and op_ci_n.
REQ-017 The carry chain SHALL be passed unchanged in logic mode (op_m=1); the block SHALL NOT interpret op_s.
REQ-018 idx SHALL be ceil(log2(NIBBLES)) bits wide, and the block SHALL require NIBBLES >= 1; NIBBLES=1 SHALL give a single RUN cycle.

Reset
REQ-019 reset=1 SHALL asynchronously force state IDLE, idx=0, busy=0, done=0, result=0, co_n=1, aeqb=0, carry register=1, and latched op/operands=0.
REQ-020 reset asserted mid-RUN SHALL abort the operation with no done pulse; the first start after release SHALL run normally.

Verification (NIBBLES=4, bench connects a behavioural 4-bit 74181 slice to the alu_* ports)
REQ-021 Add: s=1001 m=0 ci_n=1, A=1234h B=0FFFh -> done after 5 cycles, result=2233h, co_n=1.
REQ-022 Carry ripple: s=1001 m=0 ci_n=1, A=FFFFh B=0001h -> result=0000h, co_n=0.
REQ-023 Compare: s=0110 m=0 ci_n=1, A=B=5A5Ah -> result=FFFFh, aeqb=1; repeat with B=5A5Bh -> aeqb=0.
REQ-024 Logic XOR: s=0110 m=1, A=A5A5h B=0FF0h -> result=AA55h.
REQ-025 Protocol: start held high for 10 cycles -> exactly two operations run and exactly two done pulses, 6 cycles apart; reset pulse at RUN idx=2 -> busy=0 immediately, no done pulse, result=0000h.

Source files
------------

// File: rtl/alu_nibble_seq.sv
// Runs a W-bit operation through an external 4-bit ALU slice, one nibble per cycle.
// Carry ripples between nibbles via a register; the A=B flags of all nibbles are ANDed.
module alu_nibble_seq #(
  parameter  int NIBBLES = 4,
  localparam int W       = 4 * NIBBLES,
  localparam int IW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [3:0]   op_s,
  input  logic         op_m,
  input  logic         op_ci_n,
  input  logic [W-1:0] a_in,
  input  logic [W-1:0] b_in,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         co_n,
  output logic         aeqb,
  output logic [3:0]   alu_a,
  output logic [3:0]   alu_b,
  output logic [3:0]   alu_s,
  output logic         alu_m,
  output logic         alu_ci_n,
  input  logic [3:0]   alu_f,
  input  logic         alu_co_n,
  input  logic         alu_aeqb
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                    state, state_nx;
  logic [IW-1:0]             idx, sel_idx;
  logic [NIBBLES-1:0][3:0]   a_q, b_q, res_q;
  logic [3:0]                s_q;
  logic                      m_q, ci_q, carry_q, acc_q;
  logic                      last;

  assign last = (idx == IW'(NIBBLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Start is only honoured in IDLE; DONE always returns to IDLE.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last)  state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      m_q     <= 1'b0;
      ci_q    <= 1'b0;
      idx     <= '0;
      res_q   <= '0;
      carry_q <= 1'b1;
      acc_q   <= 1'b0;
      co_n    <= 1'b1;
      aeqb    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          a_q   <= a_in;
          b_q   <= b_in;
          s_q   <= op_s;
          m_q   <= op_m;
          ci_q  <= op_ci_n;
          idx   <= '0;
          res_q <= '0;
          acc_q <= 1'b1;
        end
        RUN: begin
          res_q[idx] <= alu_f;
          carry_q    <= alu_co_n;
          acc_q      <= acc_q & alu_aeqb;
          idx        <= last ? '0 : idx + 1'b1;
          if (last) begin
            co_n <= alu_co_n;
            aeqb <= acc_q & alu_aeqb;
          end
        end
        default: ;
      endcase
    end
  end

  // Outside RUN the slice sees nibble 0 with the latched carry-in.
  assign sel_idx  = (state == RUN) ? idx : '0;
  assign alu_a    = a_q[sel_idx];
  assign alu_b    = b_q[sel_idx];
  assign alu_s    = s_q;
  assign alu_m    = m_q;
  assign alu_ci_n = (state == RUN && idx != '0) ? carry_q : ci_q;

  assign result = res_q;
  assign busy   = (state != IDLE);
  assign done   = (state == DONE);

endmodule

// File: tb/tb_alu_nibble_seq.sv
// Directed bench for alu_nibble_seq with a behavioural 74181 slice on the alu_* ports.
module tb_alu_nibble_seq;
  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [3:0]   op_s = '0;
  logic         op_m = 1'b0, op_ci_n = 1'b1;
  logic [W-1:0] a_in = '0, b_in = '0;
  logic         busy, done, co_n, aeqb;
  logic [W-1:0] result;
  logic [3:0]   alu_a, alu_b, alu_s, alu_f;
  logic         alu_m, alu_ci_n, alu_co_n, alu_aeqb;

  int n_cmp = 0, n_bad = 0;

  alu_nibble_seq #(.NIBBLES(N)) dut (
    .clk(clk), .reset(reset), .start(start), .op_s(op_s), .op_m(op_m),
    .op_ci_n(op_ci_n), .a_in(a_in), .b_in(b_in), .busy(busy), .done(done),
    .result(result), .co_n(co_n), .aeqb(aeqb), .alu_a(alu_a), .alu_b(alu_b),
    .alu_s(alu_s), .alu_m(alu_m), .alu_ci_n(alu_ci_n), .alu_f(alu_f),
    .alu_co_n(alu_co_n), .alu_aeqb(alu_aeqb)
  );

  always #5 clk = ~clk;

  // 74181 (active-high data): arithmetic F = (A|X) + (A&Y) + Cn, logic F = ~((A|X)^(A&Y)).
  logic [3:0] sx, sy, t_or, t_and;
  logic [4:0] sum;
  always_comb begin
    sx    = ({4{alu_s[0]}} & alu_b) | ({4{alu_s[1]}} & ~alu_b);
    sy    = ({4{alu_s[2]}} & ~alu_b) | ({4{alu_s[3]}} & alu_b);
    t_or  = alu_a | sx;
    t_and = alu_a & sy;
    sum   = {1'b0, t_or} + {1'b0, t_and} + {4'b0, ~alu_ci_n};
    alu_f    = alu_m ? ~(t_or ^ t_and) : sum[3:0];
    alu_co_n = ~sum[4];
    alu_aeqb = (alu_f == 4'hF);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]   s;
    logic         m;
    logic         ci_n;
    logic [W-1:0] a, b;
    logic [W-1:0] res;
    logic         co_n;
    logic         chk_co;
    logic         aeqb;
  } vec_t;

  vec_t vt[7];

  task automatic run_op(input vec_t v, input int n);
    int lat;
    bit got;
    @(negedge clk);
    op_s = v.s; op_m = v.m; op_ci_n = v.ci_n; a_in = v.a; b_in = v.b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a_in = W'($urandom); b_in = W'($urandom); op_s = ~v.s; op_m = ~v.m; op_ci_n = ~v.ci_n;
    chk($sformatf("v%0d busy", n), busy, 1);
    lat = 0; got = 0;
    while (!got && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (done) got = 1;
    end
    chk($sformatf("v%0d latency", n), lat, N);
    chk($sformatf("v%0d result", n), result, v.res);
    if (v.chk_co) chk($sformatf("v%0d co_n", n), co_n, v.co_n);
    chk($sformatf("v%0d aeqb", n), aeqb, v.aeqb);
    @(posedge clk); #1;
    chk($sformatf("v%0d done_width", n), {busy, done}, 2'b00);
  endtask

  initial begin
    int done_cnt, first_done, second_done;
    vec_t add_v;
    vt[0] = '{4'b1001, 1'b0, 1'b1, 16'h1234, 16'h0FFF, 16'h2233, 1'b1, 1'b1, 1'b0};
    vt[1] = '{4'b1001, 1'b0, 1'b1, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 1'b1, 1'b0};
    vt[2] = '{4'b0110, 1'b0, 1'b1, 16'h5A5A, 16'h5A5A, 16'hFFFF, 1'b1, 1'b1, 1'b1};
    vt[3] = '{4'b0110, 1'b0, 1'b1, 16'h5A5A, 16'h5A5B, 16'hFFFE, 1'b1, 1'b1, 1'b0};
    vt[4] = '{4'b0110, 1'b1, 1'b1, 16'hA5A5, 16'h0FF0, 16'hAA55, 1'b0, 1'b0, 1'b0};
    vt[5] = '{4'b0110, 1'b0, 1'b0, 16'h1234, 16'h0FFF, 16'h0235, 1'b0, 1'b1, 1'b0};
    vt[6] = '{4'b1100, 1'b1, 1'b1, 16'h1234, 16'h0FFF, 16'hFFFF, 1'b0, 1'b0, 1'b1};
    add_v = vt[0];

    // reset state
    #12;
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst result", result, 0);
    chk("rst co_n", co_n, 1);
    chk("rst aeqb", aeqb, 0);
    chk("rst alu_a", {alu_a, alu_b, alu_s}, 0);
    chk("rst alu_ci_n", alu_ci_n, 0);
    @(negedge clk); reset = 1'b0;

    for (int i = 0; i < 7; i++) run_op(vt[i], i);

    // outputs hold while idle
    repeat (3) @(posedge clk);
    #1;
    chk("idle hold result", result, 16'hFFFF);
    chk("idle hold aeqb", aeqb, 1);
    chk("idle alu_s", {alu_s, 3'b0, alu_m}, {4'b1100, 4'b0001});

    // start held for 10 edges: two ops, done pulses 6 apart
    @(negedge clk);
    op_s = 4'b1001; op_m = 1'b0; op_ci_n = 1'b1; a_in = 16'h1234; b_in = 16'h0FFF; start = 1'b1;
    done_cnt = 0; first_done = -1; second_done = -1;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      if (i == 9) start = 1'b0;
      if (done) begin
        done_cnt++;
        if (first_done < 0) first_done = i;
        else if (second_done < 0) second_done = i;
      end
    end
    chk("held start done count", done_cnt, 2);
    chk("held start spacing", second_done - first_done, 6);
    chk("held start result", result, 16'h2233);

    // per-nibble slice drive, then reset at idx=2
    @(negedge clk);
    a_in = 16'h1234; b_in = 16'h0FFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a_in = 16'hDEAD;
    chk("run idx0 slice", {alu_a, alu_b, 3'b0, alu_ci_n}, {4'h4, 4'hF, 4'h1});
    @(posedge clk); #1;
    chk("run idx1 slice", {alu_a, alu_b, 3'b0, alu_ci_n}, {4'h3, 4'hF, 4'h0});
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    chk("abort busy", busy, 0);
    chk("abort result", result, 0);
    #3 reset = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done) done_cnt++;
    end
    chk("abort no done", done_cnt, 0);
    chk("abort result held", result, 0);
    run_op(add_v, 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end
endmodule
